// File: rtl/morse_pkg.sv
// Shared Morse definitions: sequencer states, default rates and the
// left-justified letter table (dot = 1, dash = 111, intra-letter gap = 0).
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEFAULT_CLK_HZ = 50_000_000;
  localparam int DEFAULT_SYM_HZ = 2;

  // Index 0 = 'A' ... 25 = 'Z'; lengths count symbols including the internal gaps.
  localparam logic [15:0] LETTER_PAT [26] = '{
    16'hB800, 16'hEA80, 16'hEBA0, 16'hEA00, 16'h8000, 16'hAE80, 16'hEE80,
    16'hAA00, 16'hA000, 16'hBBB8, 16'hEB80, 16'hBA80, 16'hEE00, 16'hE800,
    16'hEEE0, 16'hBBA0, 16'hEEB8, 16'hBA00, 16'hA800, 16'hE000, 16'hAE00,
    16'hAB80, 16'hBB80, 16'hEAE0, 16'hEBB8, 16'hEEA0
  };

  localparam logic [4:0] LETTER_LEN [26] = '{
    5'd5,  5'd9,  5'd11, 5'd7,  5'd1,  5'd9,  5'd9,
    5'd7,  5'd3,  5'd13, 5'd9,  5'd9,  5'd7,  5'd5,
    5'd11, 5'd11, 5'd13, 5'd7,  5'd5,  5'd3,  5'd7,
    5'd9,  5'd9,  5'd11, 5'd13, 5'd11
  };

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Handshake bundle between the letter-select logic (master) and the sequencer (slave).
interface morse_symbol_sequencer_if #(
  parameter int PAT_W = 16,
  parameter int LEN_W = $clog2(PAT_W + 1)
);
  logic [PAT_W-1:0] Pattern;
  logic [LEN_W-1:0] Length;
  logic             Start;
  logic             Repeat;
  logic             Abort;
  logic             Ready;
  logic             Busy;
  logic             Out;
  logic             Done;

  modport master (
    output Pattern, Length, Start, Repeat, Abort,
    input  Ready, Busy, Out, Done
  );

  modport slave (
    input  Pattern, Length, Start, Repeat, Abort,
    output Ready, Busy, Out, Done
  );
endinterface

// File: rtl/morse_symbol_sequencer_divider.sv
// Symbol-rate down-counter: ticks once every DIV enabled cycles, reloadable on demand.
module symbol_rate_divider #(
  parameter int DIV = 4
) (
  input  logic Clock,
  input  logic Clear_b,
  input  logic load,
  input  logic enable,
  output logic tick
);
  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] count_reg;

  assign tick = enable & (count_reg == '0);

  always_ff @(posedge Clock or negedge Clear_b) begin
    if (!Clear_b) begin
      count_reg <= '0;
    end else if (load || tick) begin
      count_reg <= RELOAD;
    end else if (enable) begin
      count_reg <= count_reg - 1'b1;
    end
  end
endmodule

// File: rtl/morse_symbol_sequencer.sv
// Plays a left-justified Morse pattern at the symbol rate, appends the
// inter-letter gap, and optionally loops until aborted.
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int CLK_HZ   = DEFAULT_CLK_HZ,
  parameter int SYM_HZ   = DEFAULT_SYM_HZ,
  parameter int PAT_W    = 16,
  parameter int GAP_SYMS = 3
) (
  input  logic Clock,
  input  logic Clear_b,
  morse_symbol_sequencer_if.slave bus
);
  localparam int DIV   = CLK_HZ / SYM_HZ;
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;
  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] GAP_L   = CNT_W'(GAP_SYMS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_reg;
  logic [PAT_W-1:0]   sreg_reg;
  logic [PAT_W-1:0]   pat_store_reg;
  logic [LEN_W-1:0]   len_store_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               rpt_reg;
  logic               out_reg;
  logic               done_reg;

  logic               tick;
  logic               accept;
  logic               letter_end;
  logic               start_letter;
  logic [LEN_W-1:0]   len_clamped;
  logic [PAT_W-1:0]   src_pat;
  logic [LEN_W-1:0]   src_len;

  assign accept = bus.Start & (state_reg == IDLE) & ~bus.Abort;

  // Final tick of a letter: end of GAP, or end of SEND when there is no gap.
  assign letter_end = tick & (cnt_reg == CNT_ONE) &
                      ((state_reg == GAP) || ((state_reg == SEND) && (GAP_SYMS == 0)));
  assign start_letter = accept | (letter_end & rpt_reg);

  always_comb begin
    len_clamped = (bus.Length > PAT_W_L) ? PAT_W_L : bus.Length;
    src_pat     = pat_store_reg;
    src_len     = len_store_reg;
    if (state_reg == IDLE) begin
      src_pat = bus.Pattern;
      src_len = len_clamped;
    end
  end

  symbol_rate_divider #(.DIV(DIV)) u_divider (
    .Clock   (Clock),
    .Clear_b (Clear_b),
    .load    (accept),
    .enable  (state_reg != IDLE),
    .tick    (tick)
  );

  always_ff @(posedge Clock or negedge Clear_b) begin
    if (!Clear_b) begin
      state_reg     <= IDLE;
      sreg_reg      <= '0;
      pat_store_reg <= '0;
      len_store_reg <= '0;
      cnt_reg       <= '0;
      rpt_reg       <= 1'b0;
      out_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.Abort) begin
        state_reg <= IDLE;
        out_reg   <= 1'b0;
      end else if (start_letter) begin
        if (state_reg == IDLE) begin
          pat_store_reg <= bus.Pattern;
          len_store_reg <= len_clamped;
          rpt_reg       <= bus.Repeat;
        end
        sreg_reg <= src_pat;
        if (src_len != '0) begin
          state_reg <= SEND;
          cnt_reg   <= CNT_W'(src_len);
          out_reg   <= src_pat[PAT_W-1];
        end else if (GAP_SYMS != 0) begin
          state_reg <= GAP;
          cnt_reg   <= GAP_L;
          out_reg   <= 1'b0;
        end else begin
          state_reg <= IDLE;
          out_reg   <= 1'b0;
          done_reg  <= 1'b1;
        end
      end else if (letter_end) begin
        state_reg <= IDLE;
        out_reg   <= 1'b0;
        done_reg  <= 1'b1;
      end else if (tick) begin
        cnt_reg <= cnt_reg - 1'b1;
        if (state_reg == SEND) begin
          sreg_reg <= sreg_reg << 1;
          if (cnt_reg == CNT_ONE) begin
            state_reg <= GAP;
            cnt_reg   <= GAP_L;
            out_reg   <= 1'b0;
          end else begin
            out_reg <= sreg_reg[PAT_W-2];
          end
        end
      end
    end
  end

  assign bus.Ready = (state_reg == IDLE);
  assign bus.Busy  = (state_reg != IDLE);
  assign bus.Out   = out_reg;
  assign bus.Done  = done_reg;
endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed bench for the Morse sequencer with DIV=4, 16-symbol patterns and a 3-symbol gap.
module tb_morse_symbol_sequencer;
  localparam int DIV  = 4;
  localparam int GAPS = 3;

  logic clk;
  logic clear_b;
  int   checks;
  int   failures;

  morse_symbol_sequencer_if #(.PAT_W(16)) bus ();

  morse_symbol_sequencer #(
    .CLK_HZ   (8),
    .SYM_HZ   (2),
    .PAT_W    (16),
    .GAP_SYMS (GAPS)
  ) dut (
    .Clock   (clk),
    .Clear_b (clear_b),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Accept a letter on the next rising edge (edge 0); returns just after that edge.
  task automatic start_letter(input logic [15:0] pat, input int len, input logic rpt);
    @(negedge clk);
    bus.Pattern = pat;
    bus.Length  = 5'(len);
    bus.Repeat  = rpt;
    bus.Start   = 1'b1;
    @(posedge clk);
    #1;
    bus.Start   = 1'b0;
    bus.Pattern = 16'h0000;
    bus.Length  = 5'd0;
    bus.Repeat  = 1'b0;
  endtask

  // Checks cycles 1..last+1 of a non-repeating letter; poke_c injects a stray Start.
  task automatic play_and_check(input string name, input logic [15:0] pat, input int len_eff,
                                input int poke_c);
    int last;
    int exp_o;
    int errs_before;
    last = (len_eff + GAPS) * DIV + 1;
    errs_before = failures;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      exp_o = (c <= len_eff * DIV) ? int'(pat[15 - (c - 1) / DIV]) : 0;
      check($sformatf("%s out c%0d", name, c), int'(bus.Out), exp_o);
      check($sformatf("%s done c%0d", name, c), int'(bus.Done), (c == last) ? 1 : 0);
      check($sformatf("%s busy c%0d", name, c), int'(bus.Busy), (c < last) ? 1 : 0);
      if (poke_c != 0 && c == poke_c) begin
        bus.Pattern = 16'hFFFF;
        bus.Length  = 5'd16;
        bus.Start   = 1'b1;
      end
      if (poke_c != 0 && c == poke_c + 1) begin
        bus.Start   = 1'b0;
        bus.Pattern = 16'h0000;
        bus.Length  = 5'd0;
      end
    end
    $display("tx %s pat=%h len=%0d errors=%0d", name, pat, len_eff, failures - errs_before);
  endtask

  initial begin
    int exp_o;
    int ph;
    logic [15:0] t_pat;
    checks      = 0;
    failures    = 0;
    clear_b     = 1'b0;
    bus.Pattern = 16'h0000;
    bus.Length  = 5'd0;
    bus.Start   = 1'b0;
    bus.Repeat  = 1'b0;
    bus.Abort   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst ready", int'(bus.Ready), 1);
    check("rst busy", int'(bus.Busy), 0);
    check("rst out", int'(bus.Out), 0);
    check("rst done", int'(bus.Done), 0);
    clear_b = 1'b1;
    @(negedge clk);
    check("idle ready", int'(bus.Ready), 1);
    $display("tx reset");

    // Letter S
    start_letter(16'hA800, 5, 1'b0);
    play_and_check("S", 16'hA800, 5, 0);

    // Zero length: gap only
    start_letter(16'hFFFF, 0, 1'b0);
    play_and_check("len0", 16'hFFFF, 0, 0);

    // Oversized length clamps to 16
    start_letter(16'hFFFF, 31, 1'b0);
    play_and_check("clamp", 16'hFFFF, 16, 0);

    // Stray Start while busy must not disturb letter E
    start_letter(16'h8000, 1, 1'b0);
    play_and_check("E_busystart", 16'h8000, 1, 3);

    // Repeat T, abort in cycle 30
    t_pat = 16'hE000;
    start_letter(t_pat, 3, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      ph    = (c - 1) % 24;
      exp_o = (ph < 12) ? int'(t_pat[15 - ph / DIV]) : 0;
      check($sformatf("rptT out c%0d", c), int'(bus.Out), exp_o);
      check($sformatf("rptT done c%0d", c), int'(bus.Done), 0);
      check($sformatf("rptT busy c%0d", c), int'(bus.Busy), 1);
      if (c == 30) bus.Abort = 1'b1;
    end
    @(negedge clk);
    bus.Abort = 1'b0;
    check("abort ready", int'(bus.Ready), 1);
    check("abort out", int'(bus.Out), 0);
    check("abort done", int'(bus.Done), 0);
    repeat (3) begin
      @(negedge clk);
      check("post abort done", int'(bus.Done), 0);
      check("post abort ready", int'(bus.Ready), 1);
    end
    $display("tx repeat T with abort");

    // Start together with Abort in IDLE is refused
    bus.Pattern = 16'hA800;
    bus.Length  = 5'd5;
    bus.Start   = 1'b1;
    bus.Abort   = 1'b1;
    @(negedge clk);
    bus.Start   = 1'b0;
    bus.Abort   = 1'b0;
    check("start+abort ready", int'(bus.Ready), 1);
    check("start+abort busy", int'(bus.Busy), 0);
    @(negedge clk);
    check("start+abort out", int'(bus.Out), 0);
    $display("tx start with abort in idle");

    // Asynchronous clear mid-SEND, then a fresh letter A
    start_letter(16'hFFFF, 16, 1'b0);
    repeat (6) @(negedge clk);
    check("pre-clear out", int'(bus.Out), 1);
    #2;
    clear_b = 1'b0;
    #1;
    check("clear out", int'(bus.Out), 0);
    check("clear ready", int'(bus.Ready), 1);
    check("clear done", int'(bus.Done), 0);
    check("clear busy", int'(bus.Busy), 0);
    @(negedge clk);
    clear_b = 1'b1;
    $display("tx async clear");
    start_letter(16'hB800, 5, 1'b0);
    play_and_check("A_after_clear", 16'hB800, 5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/morse_symbol_sequencer.md
# morse_symbol_sequencer

Parametrised Morse symbol sequencer that replaces the fixed 13-bit, free-running letter shifter in the Morse encoder top level. It accepts a left-justified on/off pattern with an explicit symbol length through a ready/start handshake. It plays the pattern at a configurable symbol rate, appends an inter-letter gap, and reports completion. It can optionally repeat the pattern until aborted. The top level drives it from the letter-select mux and routes `Out` to the LED.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency.
- `SYM_HZ`, 2, symbol rate. `DIV = CLK_HZ/SYM_HZ` is the number of clocks per symbol. Requires `DIV >= 2`.
- `PAT_W`, 16, pattern width in symbols.
- `GAP_SYMS`, 3, number of zero symbols appended after each letter. Range 0..15.
- `LEN_W`, localparam `$clog2(PAT_W+1)`.

Ports (one clock; reset is asynchronous and active-low):
- `Clock`, in, 1: sole clock.
- `Clear_b`, in, 1: asynchronous active-low reset.
- `Pattern`, in, PAT_W: symbols, MSB first. 1 = light on.
- `Length`, in, LEN_W: number of valid symbols from the MSB.
- `Start`, in, 1: request. Accepted when `Start & Ready`.
- `Repeat`, in, 1: sampled at accept. Loop the letter plus its gap until aborted.
- `Abort`, in, 1: synchronous cancel.
- `Ready`, out, 1: idle and able to accept.
- `Busy`, out, 1: in SEND or GAP.
- `Out`, out, 1: Morse output.
- `Done`, out, 1: one-cycle pulse at normal completion.

## Operation
- Reset values:
  - State is IDLE.
  - `Ready=1`, `Busy=0`, `Out=0`, `Done=0`.
  - Shift register, symbol counter and divider are all 0.
- The FSM has three states: IDLE, SEND and GAP.
- IDLE to SEND on accept:
  - Load `Pattern` into the shift register.
  - Load the clamped length into the symbol counter: `Length > PAT_W` is clamped to PAT_W.
  - Latch `Repeat`.
  - Load the divider with `DIV-1`.
- `Length == 0` on accept: go directly to GAP. No `1` symbols are emitted.
- Divider behaviour:
  - Counts down each cycle while in SEND or GAP.
  - `tick` = divider is 0; the divider then reloads `DIV-1`.
  - `tick` is not asserted in IDLE.
- SEND:
  - `Out` = shift register MSB.
  - On `tick`: shift left by 1 with zero fill and decrement the counter.
  - When the counter reaches 0 on a tick: go to GAP with the counter = `GAP_SYMS`.
- GAP:
  - `Out=0`.
  - Decrement the counter on each `tick`.
  - When the counter reaches 0 on a tick:
    - If the latched `Repeat` is set: reload the stored pattern and length and go to SEND (or to GAP again if the length was 0). No `Done` pulse.
    - Otherwise: go to IDLE and pulse `Done`.
  - `GAP_SYMS == 0`: no gap cycles. The SEND-final tick acts as the GAP-final tick.
- Stored copies of `Pattern` and the clamped length are kept for Repeat. Input changes after accept have no effect.
- `Abort`:
  - In any state, returns to IDLE on the next edge.
  - `Out=0`, no `Done` pulse.
  - Abort takes priority over `Start` in the same cycle: the start is not accepted.
- `Start` while `Ready=0` is ignored. It is not queued.
- `Ready = (state==IDLE)`. `Busy = ~Ready`.
- `Out` is registered and is 0 whenever the state is not SEND.

## Timing
- Accept on edge 0. `Out` shows `Pattern[PAT_W-1]` from cycle 1.
- Each symbol is held for exactly DIV cycles.
- Gap cycles: L·DIV+1 through (L+G)·DIV, where L = clamped length and G = `GAP_SYMS`.
- `Done` is high for exactly cycle (L+G)·DIV+1. `Ready=1` in that same cycle, so back-to-back accept is possible there.
- In Repeat mode, the first symbol of the next pass starts in cycle (L+G)·DIV+1, with no idle cycle between passes.
- Abort asserted in cycle n gives `Ready=1` and `Out=0` in cycle n+1.
- `Clear_b` low at any time forces the reset values immediately, asynchronously. Operation resumes on the first edge after release with the block in IDLE.

## Structure
- Shared package `morse_pkg`:
  - State enum `{IDLE, SEND, GAP}`.
  - Left-justified 16-bit letter constants A–Z plus their lengths, e.g. S = `16'hA800`, len 5; T = `16'hE000`, len 3.
  - Default `CLK_HZ` and `SYM_HZ`.
- One sub-module, `symbol_rate_divider`:
  - Parametrised down-counter with load, enable and zero-tick output.
  - Async active-low clear.
  - Successor of the existing rate controller.
- The FSM, shift register and counters live in the top module.

## Test plan
Use `CLK_HZ=8`, `SYM_HZ=2` (DIV=4), `PAT_W=16`, `GAP_SYMS=3`.
- Accept `Pattern=16'hA800`, `Length=5` → `Out` = 1,0,1,0,1 for 4 cycles each over cycles 1–20. `Out=0` for cycles 21–32. `Done` pulse in cycle 33 only.
- `Length=0` accept → `Out` stays 0. `Done` in cycle 13. `Busy` is 1 for cycles 1–12.
- `Length=31` with `Pattern=16'hFFFF` → clamped to 16. `Out=1` for 64 cycles. `Done` in cycle 77.
- `Repeat=1` with `16'hE000`, len 3 → `Out` pattern 1,1,1,0,0,0 per symbol, repeating with period 24 cycles and no `Done`. Abort in cycle 30 → `Out=0` and `Ready=1` in cycle 31, with no `Done`.
- `Start` asserted while `Busy` → ignored, and the running letter completes unchanged. `Start` and `Abort` together in IDLE → not accepted, `Ready` stays 1.
- `Clear_b` pulsed low mid-SEND → `Out=0`, `Ready=1`, `Done=0` immediately. A new accept after release plays correctly from cycle 1.
